// File: rtl/fade_pkg.sv
// fade_pkg: shared widths, FSM state encoding and the step-table entry type
// for the fade_sequencer block.
package fade_pkg;

    localparam int unsigned LEVEL_W    = 10;
    localparam int unsigned SPEED_W    = 11;
    // Hold field is stored at a fixed width; narrower HOLD_W values are zero-extended.
    localparam int unsigned HOLD_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2,
        NEXT = 2'd3
    } state_t;

    typedef struct packed {
        logic [LEVEL_W-1:0]    target;
        logic [SPEED_W-1:0]    speed;
        logic [HOLD_MAX_W-1:0] hold;
    } step_t;

    function automatic step_t pack_step(
        input logic [LEVEL_W-1:0]    target,
        input logic [SPEED_W-1:0]    speed,
        input logic [HOLD_MAX_W-1:0] hold
    );
        step_t s;
        s.target = target;
        s.speed  = speed;
        s.hold   = hold;
        return s;
    endfunction

endpackage

// File: rtl/fade_pwm.sv
// fade_pwm: free-running 10-bit PWM counter with a registered level compare.
// o_led is high for i_level out of every 1024 cycles and lags i_level by one cycle.
module fade_pwm import fade_pkg::*; (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [LEVEL_W-1:0] i_level,
    output logic               o_led
);

    logic [LEVEL_W-1:0] r_cnt;
    logic               r_led;

    // Advance the PWM counter and register the compare against the level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_led <= 1'b0;
        end else begin
            r_cnt <= r_cnt + LEVEL_W'(1);
            r_led <= (r_cnt < i_level);
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/fade_sequencer.sv
// fade_sequencer: steps one LED channel through a programmable table of
// {target, speed, hold} entries, ramping a 10-bit level and driving PWM.
// Optional build macro FADE_SEQ_LOOP_EN: after the last step the sequence
// wraps to entry 0 instead of returning to IDLE (o_done still pulses per pass).
// HOLD_W must not exceed 32.
module fade_sequencer import fade_pkg::*; #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned HOLD_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [LEVEL_W-1:0]       i_wr_target,
    input  logic [SPEED_W-1:0]       i_wr_speed,
    input  logic [HOLD_W-1:0]        i_wr_hold,
    input  logic [$clog2(DEPTH)-1:0] i_last_idx,
    input  logic                     i_start,
    input  logic                     i_stop,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [LEVEL_W-1:0]       o_level,
    output logic                     o_led
);

    localparam int unsigned AW = $clog2(DEPTH);

`ifdef FADE_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    step_t              r_table [DEPTH];
    state_t             r_state;
    logic [AW-1:0]      r_idx;
    step_t              r_step;
    logic [LEVEL_W-1:0] r_level;
    logic [SPEED_W-1:0] r_tick;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_last;

    logic               w_at_target;
    logic               w_tick_hit;
    logic               w_hold_end;
    logic [AW-1:0]      w_next_idx;

    // Step table: written from the control side at any time, never reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_table[i_wr_addr] <= pack_step(i_wr_target, i_wr_speed, HOLD_MAX_W'(i_wr_hold));
        end
    end

    // Compare terms for the FSM and the index of the entry to load from NEXT.
    always_comb begin
        w_at_target = (r_level == r_step.target);
        w_tick_hit  = (r_tick == r_step.speed);
        w_hold_end  = (HOLD_MAX_W'(r_hold_cnt) == r_step.hold);
        // Wrapping to 0 only matters in loop builds; otherwise NEXT exits to IDLE first.
        w_next_idx  = r_last ? '0 : r_idx + AW'(1);
    end

    // Sequencer FSM with registered busy/done and level ramp.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_step     <= '0;
            r_level    <= '0;
            r_tick     <= '0;
            r_hold_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_stop) begin
                r_state    <= IDLE;
                r_busy     <= 1'b0;
                r_tick     <= '0;
                r_hold_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_start) begin
                            r_idx   <= '0;
                            r_step  <= r_table[0];
                            r_tick  <= '0;
                            r_busy  <= 1'b1;
                            r_state <= RAMP;
                        end
                    end
                    RAMP: begin
                        if (w_at_target) begin
                            r_hold_cnt <= '0;
                            r_state    <= HOLD;
                        end else if (w_tick_hit) begin
                            r_tick  <= '0;
                            r_level <= (r_level < r_step.target) ? r_level + LEVEL_W'(1)
                                                                 : r_level - LEVEL_W'(1);
                        end else begin
                            r_tick <= r_tick + SPEED_W'(1);
                        end
                    end
                    HOLD: begin
                        if (w_hold_end) begin
                            // Last-step decision is taken here so o_done is visible during NEXT.
                            r_last  <= (r_idx == i_last_idx);
                            r_done  <= (r_idx == i_last_idx);
                            r_state <= NEXT;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                        end
                    end
                    NEXT: begin
                        if (r_last && !LOOP_EN) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_idx   <= w_next_idx;
                            r_step  <= r_table[w_next_idx];
                            r_tick  <= '0;
                            r_state <= RAMP;
                        end
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    fade_pwm u_pwm (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_level (r_level),
        .o_led   (o_led)
    );

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_level = r_level;

endmodule
